flat_top: RTL and testbench



---
 rtl/flat_top.sv | 134 +++++++++++++
 tb/tb_flat_top.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flat_top.sv
// Registered multi-function compute tile: ALU with flags, sticky accumulator,
// 32x32 multiplier, operand mux, enable counter, word fold and popcount.
module flat_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [262:0] in_flat,
  output logic [329:0] out_flat
);

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 32;
  localparam int unsigned PW  = 7;
  localparam int unsigned NWD = 8;

  logic [DW-1:0] w_a, w_b, w_c, w_d;
  logic [2:0]    w_op;
  logic          w_en, w_clr;
  logic [1:0]    w_sel;
  logic [5:0]    w_shamt;
  logic [6:0]    w_rshamt;

  assign w_a      = in_flat[63:0];
  assign w_b      = in_flat[127:64];
  assign w_c      = in_flat[191:128];
  assign w_d      = in_flat[255:192];
  assign w_op     = in_flat[258:256];
  assign w_en     = in_flat[259];
  assign w_clr    = in_flat[260];
  assign w_sel    = in_flat[262:261];
  assign w_shamt  = w_b[5:0];
  // Rotate right-part shift; S=0 gives a 64-bit shift which yields zero.
  assign w_rshamt = 7'(DW) - 7'(w_shamt);

  logic [DW:0]   w_sum, w_diff, w_acc_sum;
  logic [DW-1:0] w_alu;
  logic          w_cf;

  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff    = {1'b0, w_a} - {1'b0, w_b};
  assign w_acc_sum = {1'b0, out_flat[127:64]} + {1'b0, w_c};

  always_comb begin
    w_alu = '0;
    w_cf  = 1'b0;
    case (w_op)
      3'd0: begin
        w_alu = w_sum[DW-1:0];
        w_cf  = w_sum[DW];
      end
      3'd1: begin
        w_alu = w_diff[DW-1:0];
        w_cf  = w_diff[DW];
      end
      3'd2: w_alu = w_a & w_b;
      3'd3: w_alu = w_a | w_b;
      3'd4: w_alu = w_a ^ w_b;
      3'd5: w_alu = w_a << w_shamt;
      3'd6: w_alu = w_a >> w_shamt;
      default: w_alu = (w_a << w_shamt) | (w_a >> w_rshamt);
    endcase
  end

  logic [DW-1:0] w_mul;
  assign w_mul = DW'(w_c[CW-1:0]) * DW'(w_d[CW-1:0]);

  logic [DW-1:0] w_mux;
  always_comb begin
    w_mux = w_a;
    case (w_sel)
      2'd1:    w_mux = w_b;
      2'd2:    w_mux = w_c;
      2'd3:    w_mux = w_d;
      default: w_mux = w_a;
    endcase
  end

  logic [CW-1:0] w_fold;
  logic [PW-1:0] w_pop;
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NWD; i++) w_fold = w_fold ^ in_flat[i*CW +: CW];
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DW; i++) w_pop = w_pop + PW'(w_a[i]);
  end

  logic [DW-1:0] r_alu, r_acc, r_mul, r_mux;
  logic [CW-1:0] r_cnt, r_fold;
  logic          r_cf, r_zf, r_ovf;
  logic [PW-1:0] r_pop;

  // Per-cycle results, registered unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu  <= '0;
      r_cf   <= 1'b0;
      r_zf   <= 1'b0;
      r_mul  <= '0;
      r_mux  <= '0;
      r_fold <= '0;
      r_pop  <= '0;
    end else begin
      r_alu  <= w_alu;
      r_cf   <= w_cf;
      r_zf   <= (w_alu == '0);
      r_mul  <= w_mul;
      r_mux  <= w_mux;
      r_fold <= w_fold;
      r_pop  <= w_pop;
    end
  end

  // Accumulator state: clear beats enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_en) begin
      r_acc <= w_acc_sum[DW-1:0];
      r_ovf <= r_ovf | w_acc_sum[DW];
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign out_flat = {r_pop, r_ovf, r_zf, r_cf, r_fold, r_cnt, r_mux, r_mul, r_acc, r_alu};

endmodule

// File: tb/tb_flat_top.sv
// Directed and LCG-driven self-checking bench for flat_top.
module tb_flat_top;

  logic         clk;
  logic         rst_n;
  logic [262:0] in_flat;
  logic [329:0] out_flat;

  int checks;
  int failures;

  logic [63:0] m_acc;
  logic        m_ovf;
  logic [31:0] m_cnt;
  logic [31:0] lcg;

  flat_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [262:0] mk(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input logic [63:0] d,
                                      input logic [2:0] op, input logic en,
                                      input logic clr, input logic [1:0] sel);
    return {sel, clr, en, op, d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * 32'd1103515245 + 32'd12345;
  endfunction

  task automatic rand64(output logic [63:0] v);
    lcg = lcg_next(lcg);
    v[63:32] = lcg;
    lcg = lcg_next(lcg);
    v[31:0] = lcg;
  endtask

  // Reference model: expected outputs for one input word, advancing accumulator state.
  task automatic model_step(input logic [262:0] vin, output logic [329:0] exp);
    logic [63:0]  a, b, c, d, alu, mul, mx;
    logic [127:0] dbl;
    logic [5:0]   s;
    logic         cf;
    logic [31:0]  fold;
    logic [64:0]  t;
    a = vin[63:0]; b = vin[127:64]; c = vin[191:128]; d = vin[255:192];
    s = b[5:0];
    cf = 1'b0;
    case (vin[258:256])
      3'd0: begin t = 65'(a) + 65'(b); alu = t[63:0]; cf = t[64]; end
      3'd1: begin alu = a - b; cf = (a < b); end
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = a << s;
      3'd6: alu = a >> s;
      default: begin dbl = {a, a} << s; alu = dbl[127:64]; end
    endcase
    mul = {32'd0, c[31:0]} * {32'd0, d[31:0]};
    case (vin[262:261])
      2'd0: mx = a;
      2'd1: mx = b;
      2'd2: mx = c;
      default: mx = d;
    endcase
    fold = a[31:0] ^ a[63:32] ^ b[31:0] ^ b[63:32] ^ c[31:0] ^ c[63:32] ^ d[31:0] ^ d[63:32];
    if (vin[260]) begin
      m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
    end else if (vin[259]) begin
      t = 65'(m_acc) + 65'(c);
      m_acc = t[63:0];
      m_ovf = m_ovf | t[64];
      m_cnt = m_cnt + 32'd1;
    end
    exp = {7'($countones(a)), m_ovf, (alu == 64'd0), cf, fold, m_cnt, mx, mul, m_acc, alu};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_flat = mk(64'hDEAD_BEEF_0123_4567, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77, 3'd0, 1'b1, 1'b0, 2'd3);
    tick();
    tick();
    checks++;
    if (out_flat !== 330'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", out_flat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Build some state, then drop reset between edges.
    in_flat = mk(64'h1, 64'h2, 64'h3, 64'h4, 3'd0, 1'b1, 1'b0, 2'd1);
    tick();
    tick();
    checks++;
    if (out_flat === 330'd0) begin
      failures++;
      $display("FAIL reset_pre_state got=%h exp=nonzero", out_flat);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_flat !== 330'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", out_flat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_flat = mk(64'h5, 64'h0, 64'h0, 64'h0, 3'd2, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[255:192] !== 64'h5) begin
      failures++;
      $display("FAIL reset_release_mux got=%h exp=5", out_flat[255:192]);
    end
  endtask

  task automatic test_alu();
    logic [63:0] va [9];
    logic [63:0] vb [9];
    logic [2:0]  vop[9];
    logic [63:0] ealu[9];
    logic        ecf[9];
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;  vop[0] = 3'd0; ealu[0] = 64'h0;                 ecf[0] = 1'b1;
    va[1] = 64'h0;                   vb[1] = 64'h1;  vop[1] = 3'd1; ealu[1] = 64'hFFFF_FFFF_FFFF_FFFF; ecf[1] = 1'b1;
    va[2] = 64'h8000_0000_0000_0001; vb[2] = 64'h1;  vop[2] = 3'd7; ealu[2] = 64'h3;                 ecf[2] = 1'b0;
    va[3] = 64'h1234;                vb[3] = 64'h40; vop[3] = 3'd7; ealu[3] = 64'h1234;              ecf[3] = 1'b0;
    va[4] = 64'h1;                   vb[4] = 64'h3F; vop[4] = 3'd5; ealu[4] = 64'h8000_0000_0000_0000; ecf[4] = 1'b0;
    va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h3F; vop[5] = 3'd6; ealu[5] = 64'h1;                 ecf[5] = 1'b0;
    va[6] = 64'hF0F0;                vb[6] = 64'hFF00; vop[6] = 3'd2; ealu[6] = 64'hF000;            ecf[6] = 1'b0;
    va[7] = 64'hF0F0;                vb[7] = 64'hFF00; vop[7] = 3'd4; ealu[7] = 64'h0FF0;            ecf[7] = 1'b0;
    va[8] = 64'h10;                  vb[8] = 64'h3;  vop[8] = 3'd1; ealu[8] = 64'hD;                 ecf[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_flat = mk(va[i], vb[i], 64'h0, 64'h0, vop[i], 1'b0, 1'b0, 2'd0);
      tick();
      checks++;
      if (out_flat[63:0] !== ealu[i] || out_flat[320] !== ecf[i] || out_flat[321] !== (ealu[i] == 64'd0)) begin
        failures++;
        $display("FAIL alu_%0d got alu=%h cf=%b zf=%b exp alu=%h cf=%b", i,
                 out_flat[63:0], out_flat[320], out_flat[321], ealu[i], ecf[i]);
      end
    end
  endtask

  task automatic test_accumulator();
    logic [63:0] eacc[5];
    logic        eovf[5];
    logic [31:0] ecnt[5];
    logic        ven [5];
    logic        vclr[5];
    vclr[0] = 1; ven[0] = 0; eacc[0] = 64'h0;                   eovf[0] = 0; ecnt[0] = 0;
    vclr[1] = 0; ven[1] = 1; eacc[1] = 64'hFFFF_FFFF_FFFF_FFFF; eovf[1] = 0; ecnt[1] = 1;
    vclr[2] = 0; ven[2] = 1; eacc[2] = 64'hFFFF_FFFF_FFFF_FFFE; eovf[2] = 1; ecnt[2] = 2;
    vclr[3] = 0; ven[3] = 0; eacc[3] = 64'hFFFF_FFFF_FFFF_FFFE; eovf[3] = 1; ecnt[3] = 2;
    vclr[4] = 1; ven[4] = 1; eacc[4] = 64'h0;                   eovf[4] = 0; ecnt[4] = 0;
    for (int i = 0; i < 5; i++) begin
      in_flat = mk(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd2, ven[i], vclr[i], 2'd0);
      tick();
      checks++;
      if (out_flat[127:64] !== eacc[i] || out_flat[322] !== eovf[i] || out_flat[287:256] !== ecnt[i]) begin
        failures++;
        $display("FAIL acc_%0d got acc=%h ovf=%b cnt=%h exp acc=%h ovf=%b cnt=%h", i,
                 out_flat[127:64], out_flat[322], out_flat[287:256], eacc[i], eovf[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_mul();
    in_flat = mk(64'h0, 64'h0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'd0, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[191:128] !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL mul_max got=%h exp=fffffffe00000001", out_flat[191:128]);
    end
    in_flat = mk(64'h0, 64'h0, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0005, 3'd0, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[191:128] !== 64'hF) begin
      failures++;
      $display("FAIL mul_upper got=%h exp=f", out_flat[191:128]);
    end
  endtask

  task automatic test_mux_fold_pop();
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    in_flat = mk(64'hA, 64'hB, 64'h1234, 64'hD, 3'd0, 1'b0, 1'b0, 2'd2);
    tick();
    checks++;
    if (out_flat[255:192] !== 64'h1234) begin
      failures++;
      $display("FAIL mux_sel2 got=%h exp=1234", out_flat[255:192]);
    end
    in_flat = mk(64'hA, 64'hB, 64'h1234, 64'hD, 3'd0, 1'b0, 1'b0, 2'd3);
    tick();
    checks++;
    if (out_flat[255:192] !== 64'hD) begin
      failures++;
      $display("FAIL mux_sel3 got=%h exp=d", out_flat[255:192]);
    end
    in_flat = mk(ones, ones, ones, ones, 3'd2, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[319:288] !== 32'h0 || out_flat[329:323] !== 7'd64) begin
      failures++;
      $display("FAIL fold_pop_ones got fold=%h pop=%0d exp fold=0 pop=64", out_flat[319:288], out_flat[329:323]);
    end
    in_flat = mk(64'h0, 64'h0, 64'h0000_0100_0000_0000, 64'h0000_0001_0000_0000, 3'd0, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[319:288] !== 32'h0000_0101 || out_flat[329:323] !== 7'd0) begin
      failures++;
      $display("FAIL fold_pop_zero got fold=%h pop=%0d exp fold=101 pop=0", out_flat[319:288], out_flat[329:323]);
    end
    in_flat = mk(64'h8000_0000_0000_0101, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[329:323] !== 7'd3) begin
      failures++;
      $display("FAIL pop_three got=%0d exp=3", out_flat[329:323]);
    end
  endtask

  task automatic test_random();
    logic [63:0]  a, b, c, d;
    logic [262:0] vin;
    logic [329:0] exp;
    int           bad;
    bad = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
    lcg = 32'h1ACE_B00C;
    for (int i = 0; i < 300; i++) begin
      rand64(a); rand64(b); rand64(c); rand64(d);
      lcg = lcg_next(lcg);
      vin = {lcg[31:30], (lcg[27:24] == 4'd0), lcg[20], lcg[18:16], d, c, b, a};
      in_flat = vin;
      model_step(vin, exp);
      tick();
      checks++;
      if (out_flat !== exp) begin
        failures++;
        bad++;
        if (bad <= 5) $display("FAIL random_%0d got=%h exp=%h", i, out_flat, exp);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    in_flat = mk(64'h0, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0, 1'b1, 2'd0);
    tick();
    in_flat = mk(64'h0, 64'h0, 64'h1, 64'h0, 3'd0, 1'b0, 1'b0, 2'd0);
    force dut.r_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_cnt;
    in_flat = mk(64'h0, 64'h0, 64'h1, 64'h0, 3'd0, 1'b1, 1'b0, 2'd0);
    tick();
    checks++;
    if (out_flat[287:256] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL cnt_top got=%h exp=ffffffff", out_flat[287:256]);
    end
    tick();
    checks++;
    if (out_flat[287:256] !== 32'h0 || out_flat[127:64] !== 64'h2) begin
      failures++;
      $display("FAIL cnt_wrap got cnt=%h acc=%h exp cnt=0 acc=2", out_flat[287:256], out_flat[127:64]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_flat  = '0;
    test_reset();
    test_alu();
    test_accumulator();
    test_mul();
    test_mux_fold_pop();
    test_random();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
